// File: rtl/mem_ctrl.sv
// Single-port word memory with byte-lane writes, WAIT wait states per access and a one-cycle ready strobe.
// A held req streams one access every WAIT+2 cycles; addresses at or beyond DEPTH complete with err and no write.
module mem_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WAIT   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                capture, access;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   cur, merged;

  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture   = 1'b1;
          cnt_nxt   = 4'(WAIT);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // The RESP exit edge doubles as the next sampling point, so a held req repeats every WAIT+2 cycles.
        if (req) begin
          capture   = 1'b1;
          cnt_nxt   = 4'(WAIT);
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_range = (32'(addr_q) < DEPTH);
  assign idx      = addr_q[IDX_W-1:0];
  assign cur      = mem[idx];

  always_comb begin
    merged = cur;
    if (we_q) begin
      for (int k = 0; k < NB; k++) begin
        if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        we_q    <= we;
        addr_q  <= addr;
        be_q    <= be;
        wdata_q <= wdata;
      end
      if (access) begin
        rdata <= in_range ? merged : '0;
        err_q <= ~in_range;
      end
    end
  end

  // Memory has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (access && in_range && we_q) mem[idx] <= merged;
  end

  assign ready = (state == RESP);
  assign err   = err_q & ready;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: DUT a (DEPTH=32), DUT b (DEPTH=16) share stimulus; DUT c runs WAIT=0.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_c, we;
  logic [4:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ready_a, ready_b, ready_c;
  logic        err_a, err_b, err_c;
  logic        busy_a, busy_b, busy_c;

  int total = 0;
  int bad   = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [31:0] mm [2][32];
  int unsigned dep [2] = '{32, 16};

  always #5 clk = ~clk;

  mem_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a));

  mem_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .WAIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b));

  mem_ctrl #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .we(we), .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata_c), .ready(ready_c), .err(err_c), .busy(busy_c));

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected responses for both shared-stimulus DUTs, applying writes to the reference memories.
  task automatic push_exp(input bit w, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] word;
    for (int k = 0; k < 2; k++) begin
      if (32'(a) < dep[k]) begin
        word = mm[k][a];
        if (w) begin
          for (int j = 0; j < 4; j++) if (b[j]) word[8*j +: 8] = d[8*j +: 8];
          mm[k][a] = word;
        end
        if (k == 0) qa.push_back({1'b0, word}); else qb.push_back({1'b0, word});
      end else begin
        if (k == 0) qa.push_back({1'b1, 32'h0}); else qb.push_back({1'b1, 32'h0});
      end
    end
  endtask

  // Called at a negedge; returns at the negedge where ready_a is seen.
  task automatic issue(input bit w, input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    int lat;
    push_exp(w, a, b, d);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = ~w; addr = ~a; be = ~b; wdata = ~d;
    lat = 1;
    while (!ready_a && lat < 20) begin
      chk("busy_during_access", {32'h0, busy_a}, 33'h1);
      @(negedge clk);
      lat++;
    end
    chk("latency", 33'(lat), 33'd4);
  endtask

  always @(negedge clk) begin
    if (ready_a) begin
      if (qa.size() == 0) chk("a_unexpected_ready", 33'h1, 33'h0);
      else chk("a_response", {err_a, rdata_a}, qa.pop_front());
    end else begin
      chk("a_err_idle", {32'h0, err_a}, 33'h0);
    end
    if (ready_b) begin
      if (qb.size() == 0) chk("b_unexpected_ready", 33'h1, 33'h0);
      else chk("b_response", {err_b, rdata_b}, qb.pop_front());
    end else begin
      chk("b_err_idle", {32'h0, err_b}, 33'h0);
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
    rst_n = 1'b0; req = 1'b0; req_c = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_a", {ready_a, busy_a, err_a, rdata_a[29:0]}, 33'h0);
    chk("reset_b", {ready_b, busy_b, err_b, rdata_b[29:0]}, 33'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 5'd3, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 5'd3, 4'h0, 32'h0);
    issue(1'b1, 5'd3, 4'h5, 32'h11223344);   // merged word DE22BE44
    issue(1'b0, 5'd3, 4'hA, 32'h0);
    issue(1'b0, 5'd31, 4'hF, 32'h0);
    issue(1'b1, 5'd7, 4'h0, 32'hFFFFFFFF);
    issue(1'b0, 5'd7, 4'hF, 32'h0);
    issue(1'b1, 5'd4, 4'hF, 32'hCAFEF00D);
    issue(1'b1, 5'd20, 4'hF, 32'h55AA55AA);
    issue(1'b0, 5'd4, 4'hF, 32'h0);
    issue(1'b0, 5'd20, 4'hF, 32'h0);
    issue(1'b1, 5'd5, 4'hF, 32'h12345678);

    // Held req: addr is 3 only on the acceptance edges, garbage in between.
    for (int i = 0; i < 3; i++) push_exp(1'b0, 5'd3, 4'h0, 32'h0);
    req = 1'b1; we = 1'b0; addr = 5'd3;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("stream_ready_w2", {32'h0, ready_a}, {32'h0, (n % 4 == 0)});
      addr  = (n % 4 == 0) ? 5'd3 : 5'd9;
      we    = (n % 4 == 0) ? 1'b0 : 1'b1;
      wdata = $urandom;
      be    = 4'hF;
    end
    req = 1'b0; we = 1'b0; addr = 5'd3;

    req_c = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      chk("stream_ready_w0", {32'h0, ready_c}, {32'h0, (n % 2 == 0)});
      if (ready_c) chk("stream_w0_resp", {err_c, rdata_c}, 33'h0);
    end
    req_c = 1'b0;
    repeat (2) @(negedge clk);

    // Abort a write to addr 5 by asserting reset between clock edges.
    req = 1'b1; we = 1'b1; addr = 5'd5; be = 4'hF; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("pre_reset_busy", {32'h0, busy_a}, 33'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_a", {ready_a, busy_a, err_a, rdata_a[29:0]}, 33'h0);
    chk("async_reset_a_rdata", {1'b0, rdata_a}, 33'h0);
    chk("async_reset_b", {ready_b, busy_b, err_b, rdata_b[29:0]}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 5'd5, 4'hF, 32'h0);
    repeat (3) @(negedge clk);

    chk("queue_a_empty", 33'(qa.size()), 33'h0);
    chk("queue_b_empty", 33'(qb.size()), 33'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
